// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures each byte offered on the new_data/ack_data handshake into a
// first-word-fall-through FIFO. The CPU side reads the head entry and sees
// the fill level, a sticky overflow flag and a threshold interrupt.
module uart_rx_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned THRESHOLD = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_new_data,
    output logic                         o_ack_data,
    output logic [7:0]                   o_rd_data,
    output logic                         o_rd_valid,
    input  logic                         i_rd_en,
    input  logic                         i_clr,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    output logic                         o_irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ack_q, ack_d;
    logic          ovf_q, ovf_d;

    logic capture;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Handshake decode, push/pop qualification and next-state computation.
    always_comb begin
        capture = i_new_data && !ack_q;
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        // A flush overrides both sides: the captured byte is still acked
        // but never stored, and it does not count as a drop.
        pop     = i_rd_en && !empty && !i_clr;
        push    = capture && (!full || pop) && !i_clr;
        drop    = capture && full && !pop && !i_clr;

        ack_d   = capture;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (i_clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) ovf_d = 1'b1;
        end
    end

    // Control state: ack pulse, pointers, fill level and sticky overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Byte storage; an entry is written only on a qualified push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= i_rx_data;
        end
    end

    assign o_ack_data = ack_q;
    assign o_count    = count_q;
    assign o_rd_valid = !empty;
    assign o_overflow = ovf_q;
    assign o_irq      = (count_q >= CW'(THRESHOLD));
    // Head entry falls through; forced to zero while empty so the bus
    // never sees stale data.
    assign o_rd_data  = empty ? '0 : mem_q[rptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with directed
// scenarios followed by randomized handshake/pop/flush traffic.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned THRESHOLD = 1;
    localparam int unsigned CW        = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          new_data = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr = 1'b0;
    logic          o_ack_data;
    logic [7:0]    o_rd_data;
    logic          o_rd_valid;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_irq;

    int checks = 0;
    int errors = 0;

    // Reference model state: queue of stored bytes plus flags.
    logic [7:0] sb[$];
    int         m_cnt = 0;
    logic       m_ovf = 1'b0;
    logic       m_ack = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_new_data (new_data),
        .o_ack_data (o_ack_data),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_rd_en    (rd_en),
        .i_clr      (clr),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_irq      (o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: every offer not shadowed by an ack is acked; it is
    // stored when there is room (or room is made the same edge), else dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_ack = 1'b0;
        end else begin
            logic cap;
            logic popd;
            cap = new_data && !m_ack;
            if (clr) begin
                sb.delete();
                m_cnt = 0;
                m_ovf = 1'b0;
            end else begin
                popd = rd_en && (m_cnt > 0);
                if (cap) begin
                    if (m_cnt < int'(DEPTH) || popd) begin
                        sb.push_back(rx_data);
                        m_cnt++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (popd) m_cnt--;
            end
            m_ack = cap;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard whenever
    // the DUT presents a head byte that is about to be consumed.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack", int'(o_ack_data), int'(m_ack));
            chk("count", int'(o_count), m_cnt);
            chk("rd_valid", int'(o_rd_valid), int'(m_cnt > 0));
            chk("overflow", int'(o_overflow), int'(m_ovf));
            chk("irq", int'(o_irq), int'(m_cnt >= int'(THRESHOLD)));
            if (rd_en && o_rd_valid && !clr) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    chk("rd_data", int'(o_rd_data), int'(sb.pop_front()));
                end
            end
        end
    end

    // Receiver model: hold new_data until acked, drop it on the edge that
    // ends the ack cycle. Optional pop on the capture edge.
    task automatic send(input logic [7:0] b, input logic with_pop);
        logic got;
        got = 1'b0;
        rx_data  = b;
        new_data = 1'b1;
        rd_en    = with_pop;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            rd_en = 1'b0;
            if (o_ack_data) got = 1'b1;
        end
        chk("ack_timeout", int'(got), 1);
        @(posedge clk); #1;
        new_data = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        rd_en = 1'b1;
        while (o_rd_valid && k < 3 * int'(DEPTH)) begin
            @(posedge clk); #1;
            k++;
        end
        rd_en = 1'b0;
        chk("drain_timeout", int'(o_rd_valid), 0);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_rd_data", int'(o_rd_data), 0);

        // Single byte with THRESHOLD=1: irq follows count.
        send(8'hA5, 1'b0);
        idle(1);
        chk("single_data", int'(o_rd_data), 8'hA5);
        pop1();
        idle(1);

        // Ordering and pointer wrap.
        for (int i = 0; i < 20; i++) begin
            send(8'(i), 1'b0);
            if (i % 2 == 1) pop1();
        end
        drain();

        // Overflow: 17th byte dropped, then flush clears the flag.
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
        send(8'h77, 1'b0);
        chk("ovf_set", int'(o_overflow), 1);
        drain();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("ovf_clr", int'(o_overflow), 0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0);
        send(8'h5A, 1'b1);
        chk("full_pp_count", int'(o_count), 16);
        drain();

        // Faulty upstream holds new_data; captures only between ack pulses.
        rx_data  = 8'h3C;
        new_data = 1'b1;
        idle(6);
        new_data = 1'b0;
        chk("guard_count", int'(o_count), 3);
        drain();
        rd_en = 1'b1;
        idle(3);
        rd_en = 1'b0;

        // Async reset while half full and ack high.
        for (int i = 0; i < 8; i++) send(8'(8'hC0 + i), 1'b0);
        rx_data  = 8'hEE;
        new_data = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_ack", int'(o_ack_data), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_ack", int'(o_ack_data), 0);
        chk("areset_count", int'(o_count), 0);
        chk("areset_ovf", int'(o_overflow), 0);
        chk("areset_irq", int'(o_irq), 0);
        new_data = 1'b0;
        #1 rst_n = 1'b1;
        idle(2);

        // Randomized traffic, including held new_data and flushes.
        for (int i = 0; i < 600; i++) begin
            new_data = ($urandom_range(0, 2) != 0);
            rx_data  = 8'($urandom);
            rd_en    = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        new_data = 1'b0;
        clr      = 1'b0;
        idle(2);
        drain();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
